// File: rtl/m_mem_seq.sv
// m_mem_seq: memory-stage data-RAM sequencer.
// Takes one load/store request at a time and drives a single-port, word-wide synchronous
// RAM that has no byte write-enables. Sub-word stores are done as read-modify-write.
// Load data is taken from the addressed lane and sign- or zero-extended. Misaligned
// requests are answered with align_err and never reach the RAM.
//
// Ports
//   clk, reset              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     request handshake; req_ready is high only when idle
//   req_we/width/sign       store flag, 00 word/01 half/10 byte/11 no-op, load sign-extend
//   req_addr/req_wdata      byte address and store data (sub-word data in the low bits)
//   resp_valid              one-cycle completion pulse
//   resp_rdata/align_err    load result and misalignment flag, qualified by resp_valid
//   busy                    sequencer not idle
//   ram_en/we/addr/wdata    RAM command (word address, full-word write)
//   ram_rdata               RAM read data, valid the cycle after a read command
module m_mem_seq #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_width,
  input  logic          req_sign,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          align_err,
  output logic          busy,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StDone} state_e;

  state_e         r_state;
  logic           r_we;
  logic [1:0]     r_width;
  logic           r_sign;
  logic [AW+1:0]  r_addr;
  logic [31:0]    r_wdata;
  logic [31:0]    r_merged;
  logic           r_err;

  logic           w_misaligned;
  logic [AW-1:0]  w_word_addr;
  logic [15:0]    w_half;
  logic [7:0]     w_byte;
  logic [31:0]    w_load_data;
  logic [31:0]    w_merged;

  // Alignment is judged on the live request so the decision is made at accept time.
  assign w_misaligned = ((req_width == 2'b00) && (req_addr[1:0] != 2'b00)) ||
                        ((req_width == 2'b01) && req_addr[0]);

  assign w_word_addr = r_addr[AW+1:2];

  // Lane extraction and extension of the RAM read word.
  always_comb begin
    w_half      = r_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    w_byte      = 8'h00;
    w_load_data = 32'h0;
    case (r_addr[1:0])
      2'b00:   w_byte = ram_rdata[7:0];
      2'b01:   w_byte = ram_rdata[15:8];
      2'b10:   w_byte = ram_rdata[23:16];
      default: w_byte = ram_rdata[31:24];
    endcase
    case (r_width)
      2'b00:   w_load_data = ram_rdata;
      2'b01:   w_load_data = {{16{r_sign & w_half[15]}}, w_half};
      2'b10:   w_load_data = {{24{r_sign & w_byte[7]}}, w_byte};
      default: w_load_data = 32'h0;
    endcase
  end

  // Read word with the target lane replaced by the latched store data.
  always_comb begin
    w_merged = ram_rdata;
    if (r_width == 2'b01) begin
      if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
      else           w_merged[15:0]  = r_wdata[15:0];
    end else begin
      case (r_addr[1:0])
        2'b00:   w_merged[7:0]   = r_wdata[7:0];
        2'b01:   w_merged[15:8]  = r_wdata[7:0];
        2'b10:   w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_we     <= 1'b0;
      r_width  <= 2'b00;
      r_sign   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_merged <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_width <= req_width;
            r_sign  <= req_sign;
            r_addr  <= req_addr[AW+1:0];
            r_wdata <= req_wdata;
            r_err   <= w_misaligned;
            if (w_misaligned || (req_width == 2'b11)) r_state <= StDone;
            else if (req_we && (req_width == 2'b00))  r_state <= StWr;
            else                                      r_state <= StRd;
          end
        end
        StRd:   r_state <= StWait;
        StWait: begin
          if (r_we) begin
            r_merged <= w_merged;
            r_state  <= StWr;
          end else begin
            r_state  <= StIdle;
          end
        end
        StWr:    r_state <= StIdle;
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outputs decode the state so that an asynchronous reset clears them immediately.
  always_comb begin
    req_ready  = (r_state == StIdle);
    busy       = (r_state != StIdle);
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    align_err  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = 32'h0;
    case (r_state)
      StRd: begin
        ram_en   = 1'b1;
        ram_addr = w_word_addr;
      end
      StWait: begin
        if (!r_we) begin
          resp_valid = 1'b1;
          resp_rdata = w_load_data;
        end
      end
      StWr: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = w_word_addr;
        ram_wdata  = (r_width == 2'b00) ? r_wdata : r_merged;
        resp_valid = 1'b1;
      end
      StDone: begin
        resp_valid = 1'b1;
        align_err  = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_m_mem_seq.sv
// Testbench for m_mem_seq: table-driven request vectors against a behavioural RAM,
// plus hand-written back-to-back and reset-during-RMW sequences.
module tb_m_mem_seq;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_width;
  logic          req_sign;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          align_err;
  logic          busy;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  m_mem_seq #(.AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_width  (req_width),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .align_err  (align_err),
    .busy       (busy),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM with activity counters.
  logic [31:0]   mem [0:(1<<AW)-1];
  int            en_cnt = 0;
  int            wr_cnt = 0;
  logic [AW-1:0] last_waddr = '0;
  logic [31:0]   last_wdata = 32'h0;

  always @(posedge clk) begin
    if (ram_en) begin
      en_cnt = en_cnt + 1;
      if (ram_we) begin
        wr_cnt = wr_cnt + 1;
        last_waddr = ram_addr;
        last_wdata = ram_wdata;
        mem[ram_addr] <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  width;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          ens;
    int          wrs;
    logic [31:0] wword;
  } vec_t;

  function automatic vec_t mk(input string name, input logic we, input logic [1:0] width,
                              input logic sign, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat,
                              input logic [31:0] rdata, input logic err, input int ens,
                              input int wrs, input logic [31:0] wword);
    vec_t v;
    v.name = name; v.we = we; v.width = width; v.sign = sign; v.addr = addr;
    v.wdata = wdata; v.lat = lat; v.rdata = rdata; v.err = err; v.ens = ens;
    v.wrs = wrs; v.wword = wword;
    return v;
  endfunction

  // One request: drive at negedge, accept on posedge, then scramble req_* while busy.
  task automatic run_vec(input vec_t v);
    int lat;
    int en0;
    int wr0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_width = v.width;
    req_sign  = v.sign;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    chk({v.name, " ready"}, {31'h0, req_ready}, 32'h1);
    en0 = en_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~v.we;
    req_width = ~v.width;
    req_sign  = ~v.sign;
    req_addr  = v.addr ^ 32'h0000_0037;
    req_wdata = 32'h5A5A_5A5A;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
    chk({v.name, " latency"}, lat, v.lat);
    chk({v.name, " rdata"}, resp_rdata, v.rdata);
    chk({v.name, " align_err"}, {31'h0, align_err}, {31'h0, v.err});
    @(posedge clk);
    #1;
    chk({v.name, " ram_en count"}, en_cnt - en0, v.ens);
    chk({v.name, " ram_we count"}, wr_cnt - wr0, v.wrs);
    if (v.wrs != 0) begin
      chk({v.name, " write addr"}, {20'h0, last_waddr}, {20'h0, v.addr[13:2]});
      chk({v.name, " write data"}, last_wdata, v.wword);
    end
  endtask

  vec_t vecs[$];
  int   acc_cyc[$];
  int   wr0;

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_width = 2'b00;
    req_sign  = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;

    // name, we, width, sign, addr, wdata, lat, rdata, err, ens, wrs, wword
    vecs.push_back(mk("st_word",    1, 2'b00, 0, 32'h10, 32'hDEADBEEF, 1, 0, 0, 1, 1, 32'hDEADBEEF));
    vecs.push_back(mk("st_init",    1, 2'b00, 0, 32'h10, 32'h11223344, 1, 0, 0, 1, 1, 32'h11223344));
    vecs.push_back(mk("st_byte_12", 1, 2'b10, 0, 32'h12, 32'h000000AB, 3, 0, 0, 2, 1, 32'h11AB3344));
    vecs.push_back(mk("ld_word",    0, 2'b00, 0, 32'h10, 32'h0, 2, 32'h11AB3344, 0, 1, 0, 0));
    vecs.push_back(mk("st_init2",   1, 2'b00, 0, 32'h10, 32'h8000F0FF, 1, 0, 0, 1, 1, 32'h8000F0FF));
    vecs.push_back(mk("ld_sb_10",   0, 2'b10, 1, 32'h10, 32'h0, 2, 32'hFFFFFFFF, 0, 1, 0, 0));
    vecs.push_back(mk("ld_uh_12",   0, 2'b01, 0, 32'h12, 32'h0, 2, 32'h00008000, 0, 1, 0, 0));
    vecs.push_back(mk("ld_sh_10",   0, 2'b01, 1, 32'h10, 32'h0, 2, 32'hFFFFF0FF, 0, 1, 0, 0));
    vecs.push_back(mk("ld_ub_13",   0, 2'b10, 0, 32'h13, 32'h0, 2, 32'h00000080, 0, 1, 0, 0));
    vecs.push_back(mk("ld_sb_11",   0, 2'b10, 1, 32'h11, 32'h0, 2, 32'hFFFFFFF0, 0, 1, 0, 0));
    vecs.push_back(mk("st_half_12", 1, 2'b01, 0, 32'h12, 32'h1234ABCD, 3, 0, 0, 2, 1, 32'hABCDF0FF));
    vecs.push_back(mk("st_byte_13", 1, 2'b10, 0, 32'h13, 32'h00000077, 3, 0, 0, 2, 1, 32'h77CDF0FF));
    vecs.push_back(mk("st_byte_10", 1, 2'b10, 0, 32'h10, 32'hFFFFFF01, 3, 0, 0, 2, 1, 32'h77CDF001));
    vecs.push_back(mk("st_byte_11", 1, 2'b10, 0, 32'h11, 32'h00000022, 3, 0, 0, 2, 1, 32'h77CD2201));
    vecs.push_back(mk("st_half_10", 1, 2'b01, 0, 32'h10, 32'h00009876, 3, 0, 0, 2, 1, 32'h77CD9876));
    vecs.push_back(mk("ld_word2",   0, 2'b00, 0, 32'h10, 32'h0, 2, 32'h77CD9876, 0, 1, 0, 0));
    vecs.push_back(mk("mis_ld_w",   0, 2'b00, 0, 32'h11, 32'h0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("mis_st_h",   1, 2'b01, 0, 32'h13, 32'hFFFF, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("mis_ld_w2",  0, 2'b00, 1, 32'h12, 32'h0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("noop",       1, 2'b11, 0, 32'h11, 32'h1, 1, 0, 0, 0, 0, 0));

    // Reset state.
    #12;
    chk("reset req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset ram_en", {31'h0, ram_en}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back word stores with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_width = 2'b00;
    req_addr  = 32'h20;
    req_wdata = 32'hAAAA0001;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) chk("b2b ready in WR", {31'h0, req_ready}, 32'h0);
      if (req_valid && req_ready) acc_cyc.push_back(c);
      @(posedge clk);
      #1;
      if (acc_cyc.size() == 1) begin
        req_addr  = 32'h24;
        req_wdata = 32'hBBBB0002;
      end else if (acc_cyc.size() == 2) begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b accept count", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) chk("b2b accept spacing", acc_cyc[1] - acc_cyc[0], 2);
    chk("b2b mem[8]", mem[8], 32'hAAAA0001);
    chk("b2b mem[9]", mem[9], 32'hBBBB0002);

    // Reset during WAIT of a byte store.
    mem[4] = 32'h11223344;
    wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_width = 2'b10;
    req_sign  = 1'b0;
    req_addr  = 32'h12;
    req_wdata = 32'h000000CC;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);  // RD
    @(negedge clk);  // WAIT
    chk("rst busy before", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rst req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst outputs", {resp_valid, align_err, ram_en, ram_we}, 32'h0);
    chk("rst ram_wdata", ram_wdata, 32'h0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst no write", wr_cnt - wr0, 0);
    chk("rst mem intact", mem[4], 32'h11223344);
    run_vec(mk("ld_after_rst", 0, 2'b00, 0, 32'h10, 32'h0, 2, 32'h11223344, 0, 1, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
